// File: rtl/and_reduce_pipe_if.sv
`default_nettype none
// ============================================================
// Interface : and_reduce_pipe_if
// Operand/result handshake bundle for and_reduce_pipe.
// Optional macro: AND_REDUCE_PIPE_MASK_EN adds in_mask.
// Rev       : 1.0
// ============================================================
interface and_reduce_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic [TAG_W-1:0] in_tag;
`ifdef AND_REDUCE_PIPE_MASK_EN
    logic [WIDTH-1:0] in_mask;
`endif
    logic             out_valid;
    logic             out_ready;
    logic             out_y;
    logic [TAG_W-1:0] out_tag;

    modport master (
`ifdef AND_REDUCE_PIPE_MASK_EN
        output in_mask,
`endif
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag
    );

    modport slave (
`ifdef AND_REDUCE_PIPE_MASK_EN
        input  in_mask,
`endif
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/and_reduce_pipe.sv
`default_nettype none
// ============================================================
// Module : and_reduce_pipe
// Pipelined FANIN-ary AND/OR reduction with tag and valid/ready.
// Optional macro: AND_REDUCE_PIPE_MASK_EN adds per-bit in_mask.
// Rev    : 1.0
// ============================================================
module and_reduce_pipe #(
    parameter int WIDTH = 32,
    parameter int FANIN = 4,
    parameter int TAG_W = 6
) (
    input  wire logic         clk,
    input  wire logic         rst_aL,
    input  wire logic         flush,
    and_reduce_pipe_if.slave  bus
);

    function automatic int calc_levels(input int w, input int f);
        int n = 0;
        int c = w;
        while (c > 1) begin
            c = (c + f - 1) / f;
            n++;
        end
        if (n < 1) n = 1;
        return n;
    endfunction

    // Vector width after k tree levels.
    function automatic int lvl_w(input int k);
        int c = WIDTH;
        for (int i = 0; i < k; i++) c = (c + FANIN - 1) / FANIN;
        return c;
    endfunction

    // Bit offset of stage k's partial result inside the flat w_lvl vector.
    function automatic int lvl_off(input int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += lvl_w(i + 1);
        return s;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH, FANIN);
    localparam int TOTAL  = lvl_off(LEVELS);

    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] mode_q;
    logic [TAG_W-1:0]  tag_q [LEVELS];
    logic [LEVELS:0]   w_ready;
    logic [TOTAL-1:0]  w_lvl;
    logic [WIDTH-1:0]  w_src;
    logic              w_fire;
    logic              w_unused;

`ifdef AND_REDUCE_PIPE_MASK_EN
    // Masked-off bits become the identity of the current mode.
    assign w_src = bus.in_mode ? (bus.in_data & bus.in_mask)
                               : (bus.in_data | ~bus.in_mask);
`else
    assign w_src = bus.in_data;
`endif

    always_comb begin
        w_ready         = '0;
        w_ready[LEVELS] = bus.out_ready;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            w_ready[k] = ~valid_q[k] | w_ready[k+1];
        end
    end

    assign bus.in_ready = w_ready[0] & ~flush & rst_aL;
    assign w_fire       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_aL || flush) begin
            valid_q <= '0;
        end else begin
            if (w_ready[0]) valid_q[0] <= w_fire;
            for (int k = 1; k < LEVELS; k++) begin
                if (w_ready[k]) valid_q[k] <= valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ready[0]) begin
            mode_q[0] <= bus.in_mode;
            tag_q[0]  <= bus.in_tag;
        end
        for (int k = 1; k < LEVELS; k++) begin
            if (w_ready[k]) begin
                mode_q[k] <= mode_q[k-1];
                tag_q[k]  <= tag_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int IN_W    = lvl_w(k);
        localparam int OUT_W   = lvl_w(k + 1);
        localparam int OFF_OUT = lvl_off(k);

        logic [IN_W-1:0]        w_in;
        logic                   w_mode;
        logic [OUT_W*FANIN-1:0] w_pad;
        logic                   w_acc;
        logic [OUT_W-1:0]       data_d;
        logic [OUT_W-1:0]       data_q;

        if (k == 0) begin : g_first
            assign w_in   = w_src;
            assign w_mode = bus.in_mode;
        end else begin : g_inner
            assign w_in   = w_lvl[lvl_off(k-1) +: IN_W];
            assign w_mode = mode_q[k-1];
        end

        always_comb begin
            w_pad            = {(OUT_W*FANIN){~w_mode}};
            w_pad[IN_W-1:0]  = w_in;
            data_d           = '0;
            w_acc            = 1'b0;
            for (int j = 0; j < OUT_W; j++) begin
                w_acc = ~w_mode;
                for (int f = 0; f < FANIN; f++) begin
                    w_acc = w_mode ? (w_acc | w_pad[j*FANIN+f])
                                   : (w_acc & w_pad[j*FANIN+f]);
                end
                data_d[j] = w_acc;
            end
        end

        always_ff @(posedge clk) begin
            if (w_ready[k]) data_q <= data_d;
        end

        assign w_lvl[OFF_OUT +: OUT_W] = data_q;
    end

    // The final stage's mode bit has no downstream consumer.
    assign w_unused = mode_q[LEVELS-1];

    assign bus.out_valid = valid_q[LEVELS-1];
    assign bus.out_y     = valid_q[LEVELS-1] & w_lvl[TOTAL-1];
    assign bus.out_tag   = valid_q[LEVELS-1] ? tag_q[LEVELS-1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_and_reduce_pipe.sv
`default_nettype none
// ============================================================
// Module : tb_and_reduce_pipe
// Scoreboard bench for and_reduce_pipe (WIDTH=32 and WIDTH=10).
// Rev    : 1.0
// ============================================================
module tb_and_reduce_pipe;

    logic clk    = 1'b0;
    logic rst_aL = 1'b0;
    logic flush  = 1'b0;

    always #5 clk = ~clk;

    and_reduce_pipe_if #(.WIDTH(32), .TAG_W(6)) bus32 ();
    and_reduce_pipe_if #(.WIDTH(10), .TAG_W(6)) bus10 ();

    and_reduce_pipe #(.WIDTH(32), .FANIN(4), .TAG_W(6)) u_dut32 (
        .clk    (clk),
        .rst_aL (rst_aL),
        .flush  (flush),
        .bus    (bus32)
    );

    and_reduce_pipe #(.WIDTH(10), .FANIN(4), .TAG_W(6)) u_dut10 (
        .clk    (clk),
        .rst_aL (rst_aL),
        .flush  (flush),
        .bus    (bus10)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] q32 [$];
    logic [6:0] q10 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected {y,tag} on every output transfer.
    logic       hold32 = 1'b0;
    logic [6:0] held32 = '0;

    always @(negedge clk) begin
        if (hold32)
            chk("stable32", {bus32.out_valid, bus32.out_y, bus32.out_tag}, {1'b1, held32});
        if (bus32.out_valid === 1'b1 && bus32.out_ready === 1'b1) begin
            if (q32.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected32: got y=%0b tag=%0d, expected no output",
                         bus32.out_y, bus32.out_tag);
            end else begin
                chk("out32", {bus32.out_y, bus32.out_tag}, q32.pop_front());
            end
        end
        hold32 <= (bus32.out_valid === 1'b1) && !bus32.out_ready && !flush && rst_aL;
        held32 <= {bus32.out_y, bus32.out_tag};
    end

    always @(negedge clk) begin
        if (bus10.out_valid === 1'b1 && bus10.out_ready === 1'b1) begin
            if (q10.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected10: got y=%0b tag=%0d, expected no output",
                         bus10.out_y, bus10.out_tag);
            end else begin
                chk("out10", {bus10.out_y, bus10.out_tag}, q10.pop_front());
            end
        end
    end

    task automatic send32(input logic [31:0] d, input logic m, input logic [5:0] t, input logic y);
        bus32.in_valid = 1'b1;
        bus32.in_data  = d;
        bus32.in_mode  = m;
        bus32.in_tag   = t;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus32.in_ready) begin
                q32.push_back({y, t});
                @(posedge clk); #1;
                bus32.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept32: got in_ready=0 for 100 cycles, expected acceptance");
        bus32.in_valid = 1'b0;
    endtask

    task automatic send10(input logic [9:0] d, input logic m, input logic [5:0] t, input logic y);
        bus10.in_valid = 1'b1;
        bus10.in_data  = d;
        bus10.in_mode  = m;
        bus10.in_tag   = t;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus10.in_ready) begin
                q10.push_back({y, t});
                @(posedge clk); #1;
                bus10.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept10: got in_ready=0 for 100 cycles, expected acceptance");
        bus10.in_valid = 1'b0;
    endtask

    task automatic drain32();
        for (int i = 0; i < 50 && q32.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain32", q32.size(), 0);
    endtask

    task automatic drain10();
        for (int i = 0; i < 50 && q10.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain10", q10.size(), 0);
    endtask

    // Directed vectors: {data, mode, tag, expected y}
    logic [31:0] md_d [6] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0001_0000};
    logic        md_m [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        md_y [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    logic [9:0]  pd_d [6] = '{10'h000, 10'h200, 10'h3FF, 10'h1FF, 10'h3FE, 10'h100};
    logic        pd_m [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        pd_y [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    logic [31:0] bp_d [5] = '{32'hFFFF_FFFF, 32'hFFFF_0FFF, 32'h0000_0000,
                              32'h0040_0000, 32'hFFFF_FFFF};
    logic        bp_m [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        bp_y [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int idx;
        bus32.in_valid  = 1'b1;
        bus32.in_data   = 32'hFFFF_FFFF;
        bus32.in_mode   = 1'b0;
        bus32.in_tag    = 6'd1;
        bus32.out_ready = 1'b1;
        bus10.in_valid  = 1'b1;
        bus10.in_data   = 10'h3FF;
        bus10.in_mode   = 1'b0;
        bus10.in_tag    = 6'd1;
        bus10.out_ready = 1'b1;
`ifdef AND_REDUCE_PIPE_MASK_EN
        bus32.in_mask   = 32'hFFFF_FFFF;
        bus10.in_mask   = 10'h3FF;
`endif

        // Reset held two cycles with in_valid asserted
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_out_valid32", bus32.out_valid, 0);
            chk("rst_out_y32",     bus32.out_y, 0);
            chk("rst_out_tag32",   bus32.out_tag, 0);
            chk("rst_in_ready32",  bus32.in_ready, 0);
            chk("rst_out_valid10", bus10.out_valid, 0);
        end
        @(posedge clk); #1;
        rst_aL         = 1'b1;
        bus32.in_valid = 1'b0;
        bus10.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready32", bus32.in_ready, 1);
        chk("post_rst_out_valid32", bus32.out_valid, 0);
        @(posedge clk); #1;

        // Latency: accepted at edge N, visible after edge N+2
        bus32.in_valid = 1'b1;
        bus32.in_data  = 32'hFFFF_FFFF;
        bus32.in_mode  = 1'b0;
        bus32.in_tag   = 6'd5;
        @(negedge clk);
        chk("lat_in_ready", bus32.in_ready, 1);
        q32.push_back({1'b1, 6'd5});
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge0_valid", bus32.out_valid, 0);
        @(negedge clk);
        chk("lat_edge1_valid", bus32.out_valid, 0);
        @(negedge clk);
        chk("lat_edge2_valid", bus32.out_valid, 1);
        @(posedge clk); #1;
        send32(32'hFFFF_FFFE, 1'b0, 6'd6, 1'b0);
        drain32();
        @(posedge clk); #1;

        // Mixed AND/OR back-to-back
        for (int i = 0; i < 6; i++) send32(md_d[i], md_m[i], 6'(10 + i), md_y[i]);
        drain32();

        // WIDTH=10 padding cases
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send10(pd_d[i], pd_m[i], 6'(50 + i), pd_y[i]);
        drain10();

        // Backpressure: only three fit while the output is stalled
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 5) begin
                bus32.in_valid = 1'b1;
                bus32.in_data  = bp_d[idx];
                bus32.in_mode  = bp_m[idx];
                bus32.in_tag   = 6'(20 + idx);
            end
            @(negedge clk);
            if (bus32.in_ready && idx < 5) begin
                q32.push_back({bp_y[idx], 6'(20 + idx)});
                idx++;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", idx, 3);
        @(negedge clk);
        chk("bp_in_ready", bus32.in_ready, 0);
        @(posedge clk); #1;
        bus32.out_ready = 1'b1;
        while (idx < 5) begin
            send32(bp_d[idx], bp_m[idx], 6'(20 + idx), bp_y[idx]);
            idx++;
        end
        drain32();

        // Flush with three in flight and a concurrent input
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        send32(32'hFFFF_FFFF, 1'b0, 6'd30, 1'b1);
        send32(32'h0000_0000, 1'b1, 6'd31, 1'b0);
        send32(32'h0000_0100, 1'b1, 6'd32, 1'b1);
        flush          = 1'b1;
        bus32.in_valid = 1'b1;
        bus32.in_data  = 32'hFFFF_FFFF;
        bus32.in_mode  = 1'b0;
        bus32.in_tag   = 6'd33;
        @(negedge clk);
        chk("flush_in_ready", bus32.in_ready, 0);
        @(posedge clk); #1;
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        q32.delete();
        @(negedge clk);
        chk("flush_out_valid", bus32.out_valid, 0);
        repeat (8) @(negedge clk);
        chk("flush_no_stale", bus32.out_valid, 0);
        @(posedge clk); #1;
        send32(32'hFFFF_FFFF, 1'b0, 6'd40, 1'b1);
        drain32();

`ifdef AND_REDUCE_PIPE_MASK_EN
        @(posedge clk); #1;
        bus32.in_mask = 32'h0000_FFFF;
        send32(32'h0000_FFFF, 1'b0, 6'd60, 1'b1);
        bus32.in_mask = 32'h0000_0000;
        send32(32'h0000_0000, 1'b0, 6'd61, 1'b1);
        bus32.in_mask = 32'h0000_0000;
        send32(32'hFFFF_FFFF, 1'b1, 6'd62, 1'b0);
        bus32.in_mask = 32'hFFFF_FFFF;
        send32(32'h0000_FFFF, 1'b0, 6'd63, 1'b0);
        drain32();
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
